timer_bank: RTL and testbench

- Parametrised multi-channel programmable timer for the Game Boy core.
- Contains one shared free-running divider (DIV) and CHANNELS independent counter channels.
- Each channel has its own reload value, tap select, enable, one-shot/auto-reload mode, delayed reload and IRQ.
- Sits on the CPU I/O bus beside the interrupt controller. Used for the legacy DMG timer (channel 0) and additional system/peripheral timers.

---
 rtl/timer_bank_if.sv | 38 +++
 rtl/timer_bank.sv | 199 +++++++++++++++++++
 tb/tb_timer_bank.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_bank_if.sv
// ---------------------------------------------------------------------------
// timer_bank_if
//   CPU I/O register window of the timer bank.
//
//   cpu_sel   master->slave  register window selected
//   cpu_wr    master->slave  write strobe
//   cpu_addr  master->slave  {channel, reg}; reg 0=DIV 1=COUNT 2=RELOAD 3=CTRL
//   cpu_di    master->slave  write data
//   cpu_do    slave->master  read data (combinational)
// ---------------------------------------------------------------------------
interface timer_bank_if #(
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 8
);
    localparam int AW = 2 + $clog2(CHANNELS);

    logic             cpu_sel;
    logic             cpu_wr;
    logic [AW-1:0]    cpu_addr;
    logic [CNT_W-1:0] cpu_di;
    logic [CNT_W-1:0] cpu_do;

    modport master (
        output cpu_sel,
        output cpu_wr,
        output cpu_addr,
        output cpu_di,
        input  cpu_do
    );

    modport slave (
        input  cpu_sel,
        input  cpu_wr,
        input  cpu_addr,
        input  cpu_di,
        output cpu_do
    );
endinterface

// File: rtl/timer_bank.sv
// ---------------------------------------------------------------------------
// timer_bank
//   Shared free-running divider (DIV) plus CHANNELS independent programmable
//   counter channels. Each channel counts falling edges of a gated divider
//   tap, and on overflow runs a delayed IRQ / reload pipeline. Channel 0 acts
//   as the legacy DMG timer.
//
//   clk_sys   in   system clock
//   reset     in   synchronous, active-high
//   ce        in   tick enable; all state advances only when ce=1
//   bus       slave CPU register window (see timer_bank_if)
//   irq       out  per-channel interrupt, one ce period wide
//   div_tick  out  one ce period pulse on falling edge of divider bit TAP0-5
// ---------------------------------------------------------------------------
module timer_bank #(
    parameter int CHANNELS  = 2,
    parameter int CNT_W     = 8,
    parameter int DIV_W     = 16,
    parameter int IRQ_DELAY = 4,
    parameter int TAP0      = 9,
    parameter int TAP1      = 3,
    parameter int TAP2      = 5,
    parameter int TAP3      = 7
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                ce,
    timer_bank_if.slave         bus,
    output logic [CHANNELS-1:0] irq,
    output logic                div_tick
);
    localparam int AW    = 2 + $clog2(CHANNELS);
    localparam int DT    = TAP0 - 5;

    localparam logic [1:0] REG_DIV    = 2'd0;
    localparam logic [1:0] REG_COUNT  = 2'd1;
    localparam logic [1:0] REG_RELOAD = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic          w_wr;
    logic [1:0]    w_reg;
    logic [AW-1:0] w_ch;
    logic          w_div_wr;

    assign w_wr     = bus.cpu_sel & bus.cpu_wr & ce;
    assign w_reg    = bus.cpu_addr[1:0];
    assign w_ch     = bus.cpu_addr >> 2;
    // Any channel window's DIV register aliases the single shared divider.
    assign w_div_wr = w_wr & (w_reg == REG_DIV);

    // ------------------------------------------------------------------
    // Shared divider and div_tick edge detector
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] r_div;
    logic             r_div_bit;
    logic             r_div_tick;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of order.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_div      <= '0;
            r_div_bit  <= 1'b0;
            r_div_tick <= 1'b0;
        end else if (ce) begin
            r_div      <= w_div_wr ? '0 : r_div + DIV_W'(1);
            r_div_bit  <= r_div[DT];
            r_div_tick <= r_div_bit & ~r_div[DT];
        end
    end

    assign div_tick = r_div_tick;

    // ------------------------------------------------------------------
    // Counter channels
    // ------------------------------------------------------------------
    logic [CHANNELS*CNT_W-1:0] w_rd_flat;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [CNT_W-1:0]   r_count;
        logic [CNT_W-1:0]   r_reload;
        logic [1:0]         r_tap;
        logic               r_en;
        logic               r_mode;
        logic               r_g;
        logic [IRQ_DELAY:0] r_pipe;

        logic             w_hit;
        logic             w_cnt_wr;
        logic             w_rel_wr;
        logic             w_ctl_wr;
        logic             w_tap_bit;
        logic             w_g;
        logic             w_inc;
        logic             w_pending;
        logic             w_reload_tick;
        logic             w_ovf;
        logic [CNT_W-1:0] w_rd;

        assign w_hit    = w_wr & (w_ch == AW'(c));
        assign w_cnt_wr = w_hit & (w_reg == REG_COUNT);
        assign w_rel_wr = w_hit & (w_reg == REG_RELOAD);
        assign w_ctl_wr = w_hit & (w_reg == REG_CTRL);

        // NOTE: every combinational output gets a default before the case so
        // no path leaves it unassigned and no latch is inferred.
        always_comb begin
            w_tap_bit = r_div[TAP3];
            case (r_tap)
                2'd0:    w_tap_bit = r_div[TAP0];
                2'd1:    w_tap_bit = r_div[TAP1];
                2'd2:    w_tap_bit = r_div[TAP2];
                default: w_tap_bit = r_div[TAP3];
            endcase
        end

        // Gated clock and its falling edge. Dropping enable or moving the tap
        // while the tap bit is high is a real 1->0 edge and counts once.
        assign w_g           = r_en & w_tap_bit;
        assign w_inc         = r_g & ~w_g;
        assign w_pending     = |r_pipe[IRQ_DELAY-1:0];
        assign w_reload_tick = r_pipe[IRQ_DELAY];
        // Reload and CPU writes take priority over counting, so an increment
        // in those ticks is lost and cannot overflow.
        assign w_ovf         = w_inc & ~w_reload_tick & ~w_cnt_wr & (&r_count);

        // NOTE: all channel registers are small flops, so they take the reset
        // explicitly; nothing here is a RAM that would be left uninitialised.
        always_ff @(posedge clk_sys) begin
            if (reset) begin
                r_count  <= '0;
                r_reload <= '0;
                r_tap    <= 2'd0;
                r_en     <= 1'b0;
                r_mode   <= 1'b0;
                r_g      <= 1'b0;
                r_pipe   <= '0;
            end else if (ce) begin
                r_g <= w_g;

                if (w_rel_wr) begin
                    r_reload <= bus.cpu_di;
                end

                if (w_ctl_wr) begin
                    r_tap  <= bus.cpu_di[1:0];
                    r_en   <= bus.cpu_di[2];
                    r_mode <= bus.cpu_di[3];
                end else if (w_reload_tick && r_mode) begin
                    r_en <= 1'b0;
                end

                // A RELOAD write on the reload tick is forwarded straight
                // into COUNT; a COUNT write on that tick is dropped.
                if (w_reload_tick) begin
                    r_count <= w_rel_wr ? bus.cpu_di : r_reload;
                end else if (w_cnt_wr) begin
                    r_count <= bus.cpu_di;
                end else if (w_inc) begin
                    r_count <= r_count + CNT_W'(1);
                end

                // A COUNT write before the irq stage cancels irq and reload.
                if (w_cnt_wr && !w_reload_tick) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe <= {r_pipe[IRQ_DELAY-1:0], w_ovf};
                end
            end
        end

        always_comb begin
            w_rd = w_pending ? '0 : r_count;
            case (w_reg)
                REG_RELOAD: w_rd = r_reload;
                REG_CTRL:   w_rd = {{(CNT_W-4){1'b1}}, r_mode, r_en, r_tap};
                default:    ;
            endcase
        end

        assign w_rd_flat[c*CNT_W +: CNT_W] = w_rd;
        assign irq[c]                      = r_pipe[IRQ_DELAY];
    end

    // ------------------------------------------------------------------
    // Read mux; unmapped channel windows read all ones
    // ------------------------------------------------------------------
    always_comb begin
        bus.cpu_do = '1;
        if (w_reg == REG_DIV) begin
            bus.cpu_do = r_div[DIV_W-1 -: CNT_W];
        end else if (int'(w_ch) < CHANNELS) begin
            bus.cpu_do = w_rd_flat[int'(w_ch)*CNT_W +: CNT_W];
        end
    end
endmodule

// File: tb/tb_timer_bank.sv
// ---------------------------------------------------------------------------
// tb_timer_bank
//   Directed bench for timer_bank (CHANNELS=2, CNT_W=8, default taps).
//   Tick numbers in comments count ce ticks after the last reset release;
//   after tick k the divider holds k.
// ---------------------------------------------------------------------------
module tb_timer_bank;
    logic       clk_sys = 1'b0;
    logic       reset   = 1'b1;
    logic       ce      = 1'b1;
    logic [1:0] irq;
    logic       div_tick;

    int total = 0;
    int bad   = 0;
    logic [7:0] rd;

    timer_bank_if #(.CHANNELS(2), .CNT_W(8)) bus ();

    timer_bank #(.CHANNELS(2), .CNT_W(8)) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ce       (ce),
        .bus      (bus),
        .irq      (irq),
        .div_tick (div_tick)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        bit         wr;
        logic [2:0] waddr;
        logic [7:0] wdata;
        int         wait_n;
        logic [2:0] raddr;
        logic [7:0] exp_do;
        logic [1:0] exp_irq;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic idle_clocks(input int n);
        ce = 1'b0;
        tick(n);
        ce = 1'b1;
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
        bus.cpu_sel  = 1'b1;
        bus.cpu_wr   = 1'b1;
        bus.cpu_addr = a;
        bus.cpu_di   = d;
        @(posedge clk_sys);
        #1;
        bus.cpu_sel = 1'b0;
        bus.cpu_wr  = 1'b0;
    endtask

    task automatic rd_reg(input logic [2:0] a, output logic [7:0] d);
        bus.cpu_sel  = 1'b1;
        bus.cpu_wr   = 1'b0;
        bus.cpu_addr = a;
        #1;
        d = bus.cpu_do;
        bus.cpu_sel = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ce    = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1;
        reset = 1'b0;
    endtask

    // ch0: CTRL=0x05 (tap bit3, enabled), COUNT=0xFE, RELOAD=0x40 (ticks 1..3)
    task automatic setup_ch0();
        wr_reg(3'h3, 8'h05);
        wr_reg(3'h1, 8'hFE);
        wr_reg(3'h2, 8'h40);
    endtask

    initial begin
        // Reads/writes: ch0 DIV=0 COUNT=1 RELOAD=2 CTRL=3, ch1 = 4..7
        vecs[0]  = '{1'b1, 3'h3, 8'h05, 0,  3'h3, 8'hF5, 2'b00}; // t1
        vecs[1]  = '{1'b1, 3'h1, 8'hFE, 0,  3'h1, 8'hFE, 2'b00}; // t2
        vecs[2]  = '{1'b1, 3'h2, 8'h40, 13, 3'h1, 8'hFE, 2'b00}; // t16
        vecs[3]  = '{1'b0, 3'h0, 8'h00, 1,  3'h1, 8'hFF, 2'b00}; // t17
        vecs[4]  = '{1'b0, 3'h0, 8'h00, 15, 3'h1, 8'hFF, 2'b00}; // t32
        vecs[5]  = '{1'b0, 3'h0, 8'h00, 1,  3'h1, 8'h00, 2'b00}; // t33 overflow
        vecs[6]  = '{1'b0, 3'h0, 8'h00, 3,  3'h1, 8'h00, 2'b00}; // t36
        vecs[7]  = '{1'b0, 3'h0, 8'h00, 1,  3'h1, 8'h00, 2'b01}; // t37 irq
        vecs[8]  = '{1'b0, 3'h0, 8'h00, 1,  3'h1, 8'h40, 2'b00}; // t38 reload
        vecs[9]  = '{1'b0, 3'h0, 8'h00, 0,  3'h2, 8'h40, 2'b00};
        vecs[10] = '{1'b0, 3'h0, 8'h00, 0,  3'h5, 8'h00, 2'b00};
        vecs[11] = '{1'b0, 3'h0, 8'h00, 0,  3'h0, 8'h00, 2'b00};

        bus.cpu_sel  = 1'b0;
        bus.cpu_wr   = 1'b0;
        bus.cpu_addr = '0;
        bus.cpu_di   = '0;

        // ---- Basic overflow / irq / reload, table driven ----
        do_reset();
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) wr_reg(vecs[i].waddr, vecs[i].wdata);
            tick(vecs[i].wait_n);
            rd_reg(vecs[i].raddr, rd);
            check($sformatf("vec%0d data", i), 32'(rd), 32'(vecs[i].exp_do));
            check($sformatf("vec%0d irq", i), 32'(irq), 32'(vecs[i].exp_irq));
        end

        // ---- Reset from a dirty state ----
        do_reset();
        for (int a = 0; a < 8; a++) begin
            rd_reg(3'(a), rd);
            check($sformatf("reset reg%0d", a), 32'(rd), (a % 4 == 3) ? 32'hF0 : 32'h00);
        end
        check("reset irq", 32'(irq), 32'h0);
        check("reset div_tick", 32'(div_tick), 32'h0);

        // ---- COUNT write during pipeline cancels irq and reload ----
        do_reset();
        setup_ch0();
        tick(31);                    // t34
        wr_reg(3'h1, 8'h12);         // t35, stage 2
        for (int i = 0; i < 5; i++) begin
            tick(1);                 // t36..t40
            check($sformatf("cancel irq t%0d", 36 + i), 32'(irq), 32'h0);
        end
        rd_reg(3'h1, rd);
        check("cancel count", 32'(rd), 32'h12);
        tick(8);                     // t48
        rd_reg(3'h1, rd);
        check("cancel hold", 32'(rd), 32'h12);
        tick(1);                     // t49, next bit3 fall
        rd_reg(3'h1, rd);
        check("cancel resumes", 32'(rd), 32'h13);

        // ---- Reset mid-pipeline discards pending irq ----
        do_reset();
        setup_ch0();
        tick(32);                    // t35
        do_reset();
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check($sformatf("rst pipe irq %0d", i), 32'(irq), 32'h0);
        end

        // ---- RELOAD write on reload tick, ce gating of the irq pulse ----
        do_reset();
        setup_ch0();
        tick(34);                    // t37
        check("irq t37", 32'(irq), 32'h1);
        idle_clocks(3);
        check("irq held ce=0", 32'(irq), 32'h1);
        rd_reg(3'h1, rd);
        check("count held ce=0", 32'(rd), 32'h00);
        wr_reg(3'h2, 8'h99);         // t38 reload tick
        rd_reg(3'h1, rd);
        check("fwd reload count", 32'(rd), 32'h99);
        rd_reg(3'h2, rd);
        check("fwd reload reg", 32'(rd), 32'h99);
        check("irq t38", 32'(irq), 32'h0);

        // ---- COUNT write in irq tick is ignored ----
        do_reset();
        setup_ch0();
        tick(34);                    // t37
        wr_reg(3'h1, 8'h55);         // t38
        rd_reg(3'h1, rd);
        check("irq-tick write ignored", 32'(rd), 32'h40);

        // ---- COUNT write in last pending stage suppresses irq ----
        do_reset();
        setup_ch0();
        tick(33);                    // t36
        wr_reg(3'h1, 8'h20);         // t37, stage 3
        check("late cancel irq", 32'(irq), 32'h0);
        tick(1);                     // t38
        rd_reg(3'h1, rd);
        check("late cancel count", 32'(rd), 32'h20);
        check("late cancel no irq", 32'(irq), 32'h0);

        // ---- Disable while tap high: one spurious increment ----
        do_reset();
        wr_reg(3'h3, 8'h05);         // t1
        wr_reg(3'h1, 8'h10);         // t2
        tick(9);                     // t11
        rd_reg(3'h1, rd);
        check("dis before", 32'(rd), 32'h10);
        wr_reg(3'h3, 8'h01);         // t12, div bit3 high
        rd_reg(3'h1, rd);
        check("dis write tick", 32'(rd), 32'h10);
        tick(1);                     // t13
        rd_reg(3'h1, rd);
        check("dis spurious", 32'(rd), 32'h11);
        tick(40);
        rd_reg(3'h1, rd);
        check("dis frozen", 32'(rd), 32'h11);
        rd_reg(3'h3, rd);
        check("dis ctrl", 32'(rd), 32'hF1);

        // ---- One-shot ch1 plus simultaneous auto-reload ch0 ----
        do_reset();
        wr_reg(3'h7, 8'h0D);         // t1
        wr_reg(3'h5, 8'hFF);         // t2
        wr_reg(3'h6, 8'h80);         // t3
        wr_reg(3'h3, 8'h05);         // t4
        wr_reg(3'h1, 8'hFF);         // t5
        tick(12);                    // t17 both overflow
        rd_reg(3'h5, rd);
        check("os ch1 ovf", 32'(rd), 32'h00);
        rd_reg(3'h1, rd);
        check("os ch0 ovf", 32'(rd), 32'h00);
        tick(4);                     // t21
        check("os both irq", 32'(irq), 32'h3);
        tick(1);                     // t22
        check("os irq end", 32'(irq), 32'h0);
        rd_reg(3'h5, rd);
        check("os ch1 reload", 32'(rd), 32'h80);
        rd_reg(3'h7, rd);
        check("os ch1 ctrl", 32'(rd), 32'hF9);
        rd_reg(3'h3, rd);
        check("os ch0 ctrl", 32'(rd), 32'hF5);
        tick(40);                    // t62
        rd_reg(3'h5, rd);
        check("os ch1 frozen", 32'(rd), 32'h80);
        rd_reg(3'h1, rd);
        check("os ch0 counting", 32'(rd), 32'h02);
        check("os no irq", 32'(irq), 32'h0);

        // ---- div_tick and DIV write ----
        do_reset();
        wr_reg(3'h3, 8'h04);         // t1, ch0 tap bit9 enabled
        tick(31);                    // t32
        check("div_tick t32", 32'(div_tick), 32'h0);
        tick(1);                     // t33
        check("div_tick t33", 32'(div_tick), 32'h1);
        tick(1);                     // t34
        check("div_tick t34", 32'(div_tick), 32'h0);
        tick(4660 - 34);             // divider = 0x1234
        rd_reg(3'h0, rd);
        check("div 0x1234", 32'(rd), 32'h12);
        rd_reg(3'h1, rd);
        check("tap9 count", 32'(rd), 32'h04);
        wr_reg(3'h4, 8'hAB);         // DIV write through ch1 window
        rd_reg(3'h0, rd);
        check("div cleared", 32'(rd), 32'h00);
        check("div_tick wr tick", 32'(div_tick), 32'h0);
        tick(1);
        check("div_tick after clr", 32'(div_tick), 32'h1);
        rd_reg(3'h1, rd);
        check("div clr spurious", 32'(rd), 32'h05);
        tick(1);
        check("div_tick one pulse", 32'(div_tick), 32'h0);
        rd_reg(3'h1, rd);
        check("div clr once", 32'(rd), 32'h05);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
